// File: rtl/pkg_ram.sv
// Shared RAM-access types and constants for the load path.
package pkg_ram;

    // Operand sizes in bits
    localparam int RAM_QUAD_SIZE = 64;
    localparam int RAM_LONG_SIZE = 32;
    localparam int RAM_WORD_SIZE = 16;
    localparam int RAM_BYTE_SIZE = 8;

    // Operand type; encodings 4..7 are undefined and behave as RAM_QUAD
    typedef enum logic [2:0] {
        RAM_BYTE = 3'd0,
        RAM_WORD = 3'd1,
        RAM_LONG = 3'd2,
        RAM_QUAD = 3'd3
    } data_type_t;

    // Load sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } load_state_t;

    // Operand size in bytes; unknown types fall back to a quad
    function automatic logic [3:0] ram_type_bytes(input data_type_t dtype);
        logic [3:0] size_s;
        case (dtype)
            RAM_BYTE: size_s = 4'(RAM_BYTE_SIZE / 8);
            RAM_WORD: size_s = 4'(RAM_WORD_SIZE / 8);
            RAM_LONG: size_s = 4'(RAM_LONG_SIZE / 8);
            RAM_QUAD: size_s = 4'(RAM_QUAD_SIZE / 8);
            default:  size_s = 4'(RAM_QUAD_SIZE / 8);
        endcase
        return size_s;
    endfunction

endpackage

// File: rtl/ram_ext.sv
// Combinational zero/sign extender: right-aligned operand to DATA_WIDTH.
module ram_ext
    import pkg_ram::*;
#(
    parameter int DATA_WIDTH = RAM_QUAD_SIZE
) (
    input  logic [RAM_QUAD_SIZE-1:0] value,
    input  data_type_t               dtype,
    input  logic                     is_signed,
    output logic [DATA_WIDTH-1:0]    result
);

    // Working width covers both the widest operand and the result
    localparam int EW = (DATA_WIDTH > RAM_QUAD_SIZE) ? DATA_WIDTH : RAM_QUAD_SIZE;

    logic [EW-1:0] ext_s;

    // Pick the operand slice by type and extend it per the signed flag
    always_comb begin
        ext_s = '0;
        case (dtype)
            RAM_BYTE: begin
                if (is_signed) ext_s = EW'($signed(value[RAM_BYTE_SIZE-1:0]));
                else           ext_s = EW'(value[RAM_BYTE_SIZE-1:0]);
            end
            RAM_WORD: begin
                if (is_signed) ext_s = EW'($signed(value[RAM_WORD_SIZE-1:0]));
                else           ext_s = EW'(value[RAM_WORD_SIZE-1:0]);
            end
            RAM_LONG: begin
                if (is_signed) ext_s = EW'($signed(value[RAM_LONG_SIZE-1:0]));
                else           ext_s = EW'(value[RAM_LONG_SIZE-1:0]);
            end
            default: begin
                if (is_signed) ext_s = EW'($signed(value));
                else           ext_s = EW'(value);
            end
        endcase
        result = ext_s[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/ram_load_seq.sv
// Multi-beat big-endian load sequencer with alignment check and extension.
module ram_load_seq
    import pkg_ram::*;
#(
    parameter int DATA_WIDTH = RAM_QUAD_SIZE,
    parameter int MEM_WIDTH  = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  data_type_t            req_type,
    input  logic                  req_signed,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [MEM_WIDTH-1:0]  mem_rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err
);

    localparam int               BB        = MEM_WIDTH / 8;
    localparam int               WIDE_W    = RAM_QUAD_SIZE + MEM_WIDTH;
    localparam logic [2:0]       LANE_MASK = 3'(BB - 1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_STEP = ADDR_WIDTH'(BB);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BB - 1);

    load_state_t            state_r, state_nxt_s;
    logic [2:0]             addr_lo_r;
    data_type_t             type_r;
    logic                   signed_r;
    logic [3:0]             beat_r, last_beat_r;
    logic [RAM_QUAD_SIZE-1:0] acc_r, acc_nxt_s;
    logic                   rvalid_r;
    logic                   mem_re_r;
    logic [ADDR_WIDTH-1:0]  mem_addr_r;
    logic                   rsp_valid_r, rsp_err_r, req_ready_r;
    logic [DATA_WIDTH-1:0]  rsp_data_r, ext_s;

    logic [3:0]             req_bytes_s, req_beats_s, op_bytes_s;
    logic                   req_misal_s;
    logic [5:0]             lane_sh_s;
    logic [6:0]             opnd_bits_s;
    logic [MEM_WIDTH-1:0]   shifted_s, lane_s;
    logic [WIDE_W-1:0]      wide_s;

    // Size, beat count and alignment of the incoming request
    always_comb begin
        req_bytes_s = ram_type_bytes(req_type);
        req_misal_s = (req_addr[2:0] & 3'(req_bytes_s - 4'd1)) != 3'd0;
        if (req_bytes_s > 4'(BB)) req_beats_s = req_bytes_s / 4'(BB);
        else                      req_beats_s = 4'd1;
    end

    // Lane select for narrow operands and the next accumulator value
    always_comb begin
        op_bytes_s  = ram_type_bytes(type_r);
        lane_sh_s   = {addr_lo_r & LANE_MASK, 3'b000};
        opnd_bits_s = {op_bytes_s, 3'b000};
        shifted_s   = mem_rdata << lane_sh_s;
        if (op_bytes_s < 4'(BB)) lane_s = shifted_s >> (7'(MEM_WIDTH) - opnd_bits_s);
        else                     lane_s = mem_rdata;
        wide_s    = {acc_r, lane_s};
        acc_nxt_s = wide_s[RAM_QUAD_SIZE-1:0];
    end

    ram_ext #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
        .value     (acc_nxt_s),
        .dtype     (type_r),
        .is_signed (signed_r),
        .result    (ext_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) state_nxt_s = req_misal_s ? RESP : FETCH;
                else           state_nxt_s = IDLE;
            end
            FETCH: begin
                if (beat_r == last_beat_r) state_nxt_s = DRAIN;
                else                       state_nxt_s = FETCH;
            end
            DRAIN:   state_nxt_s = RESP;
            RESP: begin
                if (rsp_ready) state_nxt_s = IDLE;
                else           state_nxt_s = RESP;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Request latch, beat issue, data capture and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_lo_r   <= 3'd0;
            type_r      <= RAM_QUAD;
            signed_r    <= 1'b0;
            beat_r      <= 4'd0;
            last_beat_r <= 4'd0;
            acc_r       <= '0;
            rvalid_r    <= 1'b0;
            mem_re_r    <= 1'b0;
            mem_addr_r  <= '0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= '0;
            req_ready_r <= 1'b1;
        end else begin
            rvalid_r    <= mem_re_r;
            req_ready_r <= (state_nxt_s == IDLE);
            if (rvalid_r) acc_r <= acc_nxt_s;
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        addr_lo_r   <= req_addr[2:0];
                        type_r      <= req_type;
                        signed_r    <= req_signed;
                        acc_r       <= '0;
                        beat_r      <= 4'd0;
                        last_beat_r <= req_beats_s - 4'd1;
                        rsp_data_r  <= '0;
                        if (req_misal_s) begin
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                        end else begin
                            mem_re_r    <= 1'b1;
                            mem_addr_r  <= req_addr & ALIGN_MASK;
                            rsp_err_r   <= 1'b0;
                        end
                    end
                end
                FETCH: begin
                    beat_r <= beat_r + 4'd1;
                    if (beat_r == last_beat_r) mem_re_r <= 1'b0;
                    else                       mem_addr_r <= mem_addr_r + BEAT_STEP;
                end
                DRAIN: begin
                    rsp_valid_r <= 1'b1;
                    rsp_err_r   <= 1'b0;
                    rsp_data_r  <= ext_s;
                end
                RESP: begin
                    if (rsp_ready) rsp_valid_r <= 1'b0;
                end
                default: begin
                    mem_re_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign mem_re    = mem_re_r;
    assign mem_addr  = mem_addr_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_ram_load_seq.sv
// Directed bench for ram_load_seq: 8-bit and 32-bit bus instances.
module tb_ram_load_seq;
    import pkg_ram::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Narrow (8-bit bus) instance signals
    logic        n_req_valid, n_req_ready, n_req_signed, n_mem_re, n_rsp_valid, n_rsp_ready, n_rsp_err;
    logic [31:0] n_req_addr, n_mem_addr;
    data_type_t  n_req_type;
    logic [7:0]  n_mem_rdata;
    logic [63:0] n_rsp_data;

    // Wide (32-bit bus) instance signals
    logic        w_req_valid, w_req_ready, w_req_signed, w_mem_re, w_rsp_valid, w_rsp_ready, w_rsp_err;
    logic [31:0] w_req_addr, w_mem_addr;
    data_type_t  w_req_type;
    logic [31:0] w_mem_rdata;
    logic [63:0] w_rsp_data;

    ram_load_seq #(.DATA_WIDTH(64), .MEM_WIDTH(8), .ADDR_WIDTH(32)) dut_n (
        .clk(clk), .rst_n(rst_n), .req_valid(n_req_valid), .req_ready(n_req_ready),
        .req_addr(n_req_addr), .req_type(n_req_type), .req_signed(n_req_signed),
        .mem_re(n_mem_re), .mem_addr(n_mem_addr), .mem_rdata(n_mem_rdata),
        .rsp_valid(n_rsp_valid), .rsp_ready(n_rsp_ready), .rsp_data(n_rsp_data), .rsp_err(n_rsp_err)
    );

    ram_load_seq #(.DATA_WIDTH(64), .MEM_WIDTH(32), .ADDR_WIDTH(32)) dut_w (
        .clk(clk), .rst_n(rst_n), .req_valid(w_req_valid), .req_ready(w_req_ready),
        .req_addr(w_req_addr), .req_type(w_req_type), .req_signed(w_req_signed),
        .mem_re(w_mem_re), .mem_addr(w_mem_addr), .mem_rdata(w_mem_rdata),
        .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_data(w_rsp_data), .rsp_err(w_rsp_err)
    );

    // Byte memories; the wide one holds the word 0x80000001 at 0x14
    logic [7:0] mem_n [256];
    logic [7:0] mem_w [256];

    always @(posedge clk) begin
        if (n_mem_re) n_mem_rdata <= mem_n[n_mem_addr[7:0]];
        if (w_mem_re) w_mem_rdata <= {mem_w[w_mem_addr[7:0]], mem_w[w_mem_addr[7:0] + 8'd1],
                                      mem_w[w_mem_addr[7:0] + 8'd2], mem_w[w_mem_addr[7:0] + 8'd3]};
    end

    // Selected-instance views used by the shared tasks
    bit          cur_wide;
    logic        s_req_ready, s_mem_re, s_rsp_valid, s_rsp_err;
    logic [31:0] s_mem_addr;
    logic [63:0] s_rsp_data;
    assign s_req_ready = cur_wide ? w_req_ready : n_req_ready;
    assign s_mem_re    = cur_wide ? w_mem_re    : n_mem_re;
    assign s_rsp_valid = cur_wide ? w_rsp_valid : n_rsp_valid;
    assign s_rsp_err   = cur_wide ? w_rsp_err   : n_rsp_err;
    assign s_mem_addr  = cur_wide ? w_mem_addr  : n_mem_addr;
    assign s_rsp_data  = cur_wide ? w_rsp_data  : n_rsp_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic drive_req(input bit wide, input logic v, input data_type_t t,
                             input logic [31:0] a, input logic sg);
        cur_wide = wide;
        if (wide) begin
            w_req_valid = v; w_req_type = t; w_req_addr = a; w_req_signed = sg;
        end else begin
            n_req_valid = v; n_req_type = t; n_req_addr = a; n_req_signed = sg;
        end
    endtask

    // Issue one load, measure latency / beats / addresses, compare the response
    task automatic run_load(input string nm, input bit wide, input data_type_t t, input logic [31:0] a,
                            input logic sg, input logic [63:0] exp_d, input logic exp_e,
                            input int exp_lat, input int exp_re);
        int lat, re_cnt, addr_bad, bb;
        logic [31:0] base;
        bb   = wide ? 4 : 1;
        base = a & ~(32'(bb - 1));
        drive_req(wide, 1'b1, t, a, sg);
        check({nm, "_ready"}, 64'(s_req_ready), 64'd1);
        @(posedge clk); #1;
        drive_req(wide, 1'b0, t, a, sg);
        lat = 1; re_cnt = 0; addr_bad = 0;
        while (!s_rsp_valid && lat < 40) begin
            if (s_mem_re) begin
                if (s_mem_addr !== base + 32'(re_cnt * bb)) addr_bad++;
                re_cnt++;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (s_mem_re) re_cnt++;
        check({nm, "_lat"}, 64'(lat), 64'(exp_lat));
        check({nm, "_beats"}, 64'(re_cnt), 64'(exp_re));
        check({nm, "_addr"}, 64'(addr_bad), 64'd0);
        check({nm, "_data"}, s_rsp_data, exp_d);
        check({nm, "_err"}, 64'(s_rsp_err), 64'(exp_e));
        @(posedge clk); #1;
        check({nm, "_done"}, 64'({s_rsp_valid, s_req_ready}), 64'b01);
    endtask

    typedef struct {
        bit          wide;
        data_type_t  t;
        logic [31:0] a;
        logic        sg;
        logic [63:0] d;
        logic        e;
        int          lat;
        int          re;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int lat, cnt;
        for (int i = 0; i < 256; i++) begin mem_n[i] = 8'h00; mem_w[i] = 8'h00; end
        for (int i = 0; i < 8; i++) mem_n[8'h10 + i] = 8'(i + 1);
        mem_n[8'h20] = 8'h80;
        mem_w[8'h10] = 8'h11; mem_w[8'h11] = 8'h22; mem_w[8'h12] = 8'h33; mem_w[8'h13] = 8'h44;
        mem_w[8'h14] = 8'h80; mem_w[8'h17] = 8'h01;

        vecs[0]  = '{0, RAM_QUAD, 32'h10, 1'b0, 64'h0102030405060708, 1'b0, 10, 8};
        vecs[1]  = '{0, RAM_BYTE, 32'h20, 1'b1, 64'hFFFFFFFFFFFFFF80, 1'b0, 3, 1};
        vecs[2]  = '{0, RAM_BYTE, 32'h20, 1'b0, 64'h0000000000000080, 1'b0, 3, 1};
        vecs[3]  = '{0, RAM_WORD, 32'h11, 1'b0, 64'h0, 1'b1, 1, 0};
        vecs[4]  = '{0, RAM_LONG, 32'h14, 1'b0, 64'h0000000005060708, 1'b0, 6, 4};
        vecs[5]  = '{0, RAM_WORD, 32'h20, 1'b1, 64'hFFFFFFFFFFFF8000, 1'b0, 4, 2};
        vecs[6]  = '{0, data_type_t'(3'd5), 32'h10, 1'b1, 64'h0102030405060708, 1'b0, 10, 8};
        vecs[7]  = '{0, RAM_LONG, 32'h12, 1'b1, 64'h0, 1'b1, 1, 0};
        vecs[8]  = '{0, RAM_QUAD, 32'h14, 1'b0, 64'h0, 1'b1, 1, 0};
        vecs[9]  = '{0, RAM_BYTE, 32'h13, 1'b1, 64'h0000000000000004, 1'b0, 3, 1};
        vecs[10] = '{1, RAM_LONG, 32'h14, 1'b1, 64'hFFFFFFFF80000001, 1'b0, 3, 1};
        vecs[11] = '{1, RAM_BYTE, 32'h17, 1'b0, 64'h0000000000000001, 1'b0, 3, 1};
        vecs[12] = '{1, RAM_QUAD, 32'h10, 1'b0, 64'h1122334480000001, 1'b0, 4, 2};
        vecs[13] = '{1, RAM_WORD, 32'h14, 1'b1, 64'hFFFFFFFFFFFF8000, 1'b0, 3, 1};
        vecs[14] = '{1, RAM_BYTE, 32'h14, 1'b1, 64'hFFFFFFFFFFFFFF80, 1'b0, 3, 1};

        cur_wide = 1'b0;
        n_req_valid = 1'b0; n_req_type = RAM_BYTE; n_req_addr = 32'h0; n_req_signed = 1'b0; n_rsp_ready = 1'b1;
        w_req_valid = 1'b0; w_req_type = RAM_BYTE; w_req_addr = 32'h0; w_req_signed = 1'b0; w_rsp_ready = 1'b1;

        // Reset values
        #12;
        check("rst_ready", 64'(n_req_ready), 64'd1);
        check("rst_mem_re", 64'(n_mem_re), 64'd0);
        check("rst_mem_addr", 64'(n_mem_addr), 64'd0);
        check("rst_rsp_valid", 64'(n_rsp_valid), 64'd0);
        check("rst_rsp_data", n_rsp_data, 64'd0);
        check("rst_rsp_err", 64'(n_rsp_err), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++)
            run_load($sformatf("v%0d", i), vecs[i].wide, vecs[i].t, vecs[i].a, vecs[i].sg,
                     vecs[i].d, vecs[i].e, vecs[i].lat, vecs[i].re);

        // Backpressure with a second request waiting
        n_rsp_ready = 1'b0;
        drive_req(1'b0, 1'b1, RAM_LONG, 32'h14, 1'b0);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, RAM_LONG, 32'h14, 1'b0);
        lat = 1;
        while (!n_rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check("bp_lat", 64'(lat), 64'd6);
        drive_req(1'b0, 1'b1, RAM_BYTE, 32'h20, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_hold_valid%0d", k), 64'(n_rsp_valid), 64'd1);
            check($sformatf("bp_hold_data%0d", k), n_rsp_data, 64'h0000000005060708);
            check($sformatf("bp_hold_ready%0d", k), 64'({n_req_ready, n_mem_re}), 64'b00);
            @(posedge clk); #1;
        end
        n_rsp_ready = 1'b1;
        check("bp_last_valid", 64'(n_rsp_valid), 64'd1);
        @(posedge clk); #1;
        check("bp_after_hs", 64'({n_rsp_valid, n_req_ready}), 64'b01);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, RAM_BYTE, 32'h20, 1'b1);
        check("bp_second_accepted", 64'(n_req_ready), 64'd0);
        lat = 1;
        while (!n_rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check("bp_second_lat", 64'(lat), 64'd3);
        check("bp_second_data", n_rsp_data, 64'hFFFFFFFFFFFFFF80);
        @(posedge clk); #1;

        // Reset during beat 3 of a quad load
        drive_req(1'b0, 1'b1, RAM_QUAD, 32'h10, 1'b0);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, RAM_QUAD, 32'h10, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_pre_re", 64'(n_mem_re), 64'd1);
        check("mid_pre_addr", 64'(n_mem_addr), 64'h12);
        rst_n = 1'b0;
        #1;
        check("mid_rst_re", 64'(n_mem_re), 64'd0);
        check("mid_rst_valid", 64'(n_rsp_valid), 64'd0);
        check("mid_rst_ready", 64'(n_req_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (n_rsp_valid || n_mem_re) cnt++;
            @(posedge clk); #1;
        end
        check("mid_no_rsp", 64'(cnt), 64'd0);
        run_load("post_rst", 1'b0, RAM_LONG, 32'h14, 1'b0, 64'h0000000005060708, 1'b0, 6, 4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
